// File: rtl/keynsham_spislave.sv
// SPI mode-0 byte slave with a four-register bus window (CTRL, STATUS, RXDATA, TXDATA).
// Latency: bus_ack and read data one cycle after access; SPI inputs see 3-4 clk synchroniser delay.
// Backpressure: none on the bus; unread RX bytes raise rx_overrun. Optional SPISLAVE_IRQ_EN adds irq output.
module keynsham_spislave #(
  parameter logic [31:0] bus_address = 32'h0,
  parameter logic [31:0] bus_size    = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
`ifdef SPISLAVE_IRQ_EN
  output logic        irq,
`endif
  input  logic        bus_access,
  output logic        bus_cs,
  input  logic [29:0] bus_addr,
  input  logic [31:0] bus_wr_val,
  input  logic        bus_wr_en,
  input  logic [3:0]  bus_bytesel,
  output logic        bus_error,
  output logic        bus_ack,
  output logic [31:0] bus_data,
  input  logic        ss_n,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso
);

  // synchroniser and edge-detect state
  logic ss_meta, ss_s, ss_d;
  logic sclk_meta, sclk_s, sclk_d;
  logic mosi_meta, mosi_s;

  // register state
  logic       enable;
  logic       rx_valid, tx_empty, rx_overrun;
  logic [7:0] rx_shift, tx_shift, rx_data, tx_hold;
  logic [2:0] bit_cnt;
  logic       reload_pend;  // a byte completed; reload tx shifter on the next sclk fall

  // address window decode (33-bit so base+size cannot wrap)
  logic [32:0] byte_addr, win_lo, win_hi;
  assign byte_addr = {1'b0, bus_addr, 2'b00};
  assign win_lo    = {1'b0, bus_address};
  assign win_hi    = {1'b0, bus_address} + {1'b0, bus_size};
  assign bus_cs    = (byte_addr >= win_lo) && (byte_addr < win_hi);
  assign bus_error = 1'b0;

  logic acc, rd, wr, rd_rx, wr_ctrl, wr_stat, wr_tx;
  assign acc     = bus_access & bus_cs;
  assign rd      = acc & ~bus_wr_en;
  assign wr      = acc & bus_wr_en;
  assign rd_rx   = rd & (bus_addr[1:0] == 2'd2);
  assign wr_ctrl = wr & (bus_addr[1:0] == 2'd0);
  assign wr_stat = wr & (bus_addr[1:0] == 2'd1);
  assign wr_tx   = wr & (bus_addr[1:0] == 2'd3);

  // bytesel and upper write bits carry no meaning for these registers
  logic unused_bits;
  assign unused_bits = ^{bus_bytesel, bus_wr_val[31:8]};

  // SPI event qualification: nothing happens while disabled, clock edges only while selected
  logic spi_on, sclk_rise, sclk_fall, ss_fall_ev, ss_rise_ev;
  logic [7:0] rx_byte, tx_load_val;
  assign spi_on      = enable & ~ss_s;
  assign sclk_rise   = spi_on & sclk_s & ~sclk_d;
  assign sclk_fall   = spi_on & ~sclk_s & sclk_d;
  assign ss_fall_ev  = enable & ss_d & ~ss_s;
  assign ss_rise_ev  = enable & ~ss_d & ss_s;
  assign rx_byte     = {rx_shift[6:0], mosi_s};
  assign tx_load_val = tx_empty ? 8'hFF : tx_hold;

  assign miso = spi_on & tx_shift[7];

  // two-flop synchronisers plus a delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_meta   <= 1'b1; ss_s   <= 1'b1; ss_d   <= 1'b1;
      sclk_meta <= 1'b0; sclk_s <= 1'b0; sclk_d <= 1'b0;
      mosi_meta <= 1'b0; mosi_s <= 1'b0;
    end else begin
      ss_meta   <= ss_n;  ss_s   <= ss_meta;   ss_d   <= ss_s;
      sclk_meta <= sclk;  sclk_s <= sclk_meta; sclk_d <= sclk_s;
      mosi_meta <= mosi;  mosi_s <= mosi_meta;
    end
  end

`ifdef SPISLAVE_IRQ_EN
  logic rx_irq_en, tx_irq_en;

  // CTRL register with interrupt enables
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable    <= 1'b0;
      rx_irq_en <= 1'b0;
      tx_irq_en <= 1'b0;
    end else if (wr_ctrl) begin
      enable    <= bus_wr_val[0];
      rx_irq_en <= bus_wr_val[1];
      tx_irq_en <= bus_wr_val[2];
    end
  end

  // registered interrupt request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= (rx_valid & rx_irq_en) | (tx_empty & tx_irq_en) | rx_overrun;
  end

  logic [31:0] ctrl_val;
  assign ctrl_val = {29'd0, tx_irq_en, rx_irq_en, enable};
`else
  // CTRL register: enable only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       enable <= 1'b0;
    else if (wr_ctrl) enable <= bus_wr_val[0];
  end

  logic [31:0] ctrl_val;
  assign ctrl_val = {31'd0, enable};
`endif

  // read mux; TXDATA and writes read as zero
  logic [31:0] rd_val;
  always_comb begin
    rd_val = 32'd0;
    if (rd) begin
      case (bus_addr[1:0])
        2'd0:    rd_val = ctrl_val;
        2'd1:    rd_val = {28'd0, ~ss_s, rx_overrun, tx_empty, rx_valid};
        2'd2:    rd_val = {24'd0, rx_data};
        default: rd_val = 32'd0;
      endcase
    end
  end

  // bus response: ack and data together, one cycle after the access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_ack  <= 1'b0;
      bus_data <= 32'd0;
    end else begin
      bus_ack  <= acc;
      bus_data <= rd_val;
    end
  end

  // SPI shifting and flags; later assignments give SPI priority over RX read and TX write over SPI load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid    <= 1'b0;
      tx_empty    <= 1'b1;
      rx_overrun  <= 1'b0;
      rx_shift    <= 8'd0;
      tx_shift    <= 8'd0;
      rx_data     <= 8'd0;
      tx_hold     <= 8'd0;
      bit_cnt     <= 3'd0;
      reload_pend <= 1'b0;
    end else begin
      if (rd_rx) rx_valid <= 1'b0;
      if (wr_stat && bus_wr_val[2]) rx_overrun <= 1'b0;

      if (!enable) begin
        bit_cnt     <= 3'd0;
        reload_pend <= 1'b0;
      end else if (ss_fall_ev) begin
        bit_cnt     <= 3'd0;
        rx_shift    <= 8'd0;
        tx_shift    <= tx_load_val;
        tx_empty    <= 1'b1;
        reload_pend <= 1'b0;
      end else if (ss_rise_ev) begin
        bit_cnt     <= 3'd0;
        reload_pend <= 1'b0;
      end else begin
        if (sclk_rise) begin
          rx_shift <= rx_byte;
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            reload_pend <= 1'b1;
            if (!rx_valid || rd_rx) begin
              rx_data  <= rx_byte;
              rx_valid <= 1'b1;
            end else begin
              rx_overrun <= 1'b1;
            end
          end
        end
        if (sclk_fall) begin
          if (reload_pend) begin
            tx_shift    <= tx_load_val;
            tx_empty    <= 1'b1;
            reload_pend <= 1'b0;
          end else begin
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
      end

      if (wr_tx) begin
        tx_hold  <= bus_wr_val[7:0];
        tx_empty <= 1'b0;
      end
    end
  end

endmodule
